f1_sweep_ctrl: RTL and testbench

Sequencer that drives the f1 combinational block (out_x = a XOR b, out_y = (out_x AND c) OR b) through all 8 input vectors. For each vector it waits a programmable settle time and captures {x,y} into a packed 16-bit result table. A start/busy/done handshake lets a host or bench run repeatable sweeps. It sits between a test or host controller and one f1 instance; vector outputs connect to f1's in_a/in_b/in_c, and f1's out_x/out_y return on in_x/in_y.

---
 rtl/f1_sweep_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_f1_sweep_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_sweep_ctrl.sv
// f1_sweep_ctrl: steps the f1 block through all 8 input vectors,
// waits a settle window per vector and packs {x,y} into a 16-bit table.
// Optional golden compare: define GOLDEN_CHECK_EN.
module f1_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_start,
    input  logic        in_abort,
    input  logic        in_x,
    input  logic        in_y,
    output logic        out_a,
    output logic        out_b,
    output logic        out_c,
    output logic [2:0]  out_vec_idx,
    output logic        out_busy,
    output logic        out_done,
    output logic [15:0] out_table,
    output logic [7:0]  out_err_mask,
    output logic        out_pass
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CAPTURE
    } state_t;

    // A settle time of zero still needs one cycle of dwell.
    localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF);

    state_t            state_q;
    state_t            state_n;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_n;
    logic [2:0]        idx_q;
    logic [2:0]        idx_n;
    logic              busy_q;
    logic              busy_n;
    logic              done_q;
    logic              done_n;
    logic [15:0]       tbl_q;
    logic [15:0]       tbl_n;

    logic              start_fire;
    logic              abort_fire;
    logic              cap_fire;
    logic              last_vec;

    // Qualified events shared by the sequencer and the golden checker.
    always_comb begin
        start_fire = (state_q == IDLE) && in_start && !in_abort;
        abort_fire = (state_q != IDLE) && in_abort;
        cap_fire   = (state_q == CAPTURE) && !in_abort;
        last_vec   = (idx_q == 3'd7);
    end

    // Sequencer next-state and datapath updates; abort overrides capture.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        busy_n  = busy_q;
        done_n  = done_q;
        tbl_n   = tbl_q;
        if (abort_fire) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = 3'd0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_fire) begin
                        state_n = SETTLE;
                        cnt_n   = CNT_LOAD;
                        idx_n   = 3'd0;
                        busy_n  = 1'b1;
                        done_n  = 1'b0;
                        tbl_n   = '0;
                    end
                end
                SETTLE: begin
                    cnt_n = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_n = CAPTURE;
                    end
                end
                CAPTURE: begin
                    tbl_n[{idx_q, 1'b0} +: 2] = {in_x, in_y};
                    if (last_vec) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                        idx_n   = 3'd0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = SETTLE;
                        cnt_n   = CNT_LOAD;
                        idx_n   = idx_q + 3'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state register with synchronous active-low reset.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tbl_q   <= '0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            tbl_q   <= tbl_n;
        end
    end

`ifdef GOLDEN_CHECK_EN
    logic [7:0] mask_q;
    logic [7:0] mask_n;
    logic       pass_q;
    logic       pass_n;
    logic [1:0] gold;
    logic       miss;
    logic [7:0] hit;

    function automatic logic [1:0] golden(input logic [2:0] v);
        logic gx;
        logic gy;
        gx = v[2] ^ v[1];
        gy = (gx & v[0]) | v[1];
        return {gx, gy};
    endfunction

    // Compare each capture with the reference f1 and track the verdict.
    always_comb begin
        gold   = golden(idx_q);
        miss   = (gold != {in_x, in_y});
        hit    = 8'(miss) << idx_q;
        mask_n = mask_q;
        pass_n = pass_q;
        if (start_fire) begin
            mask_n = '0;
            pass_n = 1'b0;
        end else if (abort_fire) begin
            pass_n = 1'b0;
        end else if (cap_fire) begin
            mask_n = mask_q | hit;
            if (last_vec) begin
                pass_n = (mask_n == 8'd0);
            end
        end
    end

    // Golden verdict registers.
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            mask_q <= '0;
            pass_q <= 1'b0;
        end else begin
            mask_q <= mask_n;
            pass_q <= pass_n;
        end
    end

    assign out_err_mask = mask_q;
    assign out_pass     = pass_q;
`else
    logic unused_cap;
    assign unused_cap   = cap_fire;
    assign out_err_mask = 8'd0;
    assign out_pass     = 1'b0;
`endif

    assign out_a       = idx_q[2];
    assign out_b       = idx_q[1];
    assign out_c       = idx_q[0];
    assign out_vec_idx = idx_q;
    assign out_busy    = busy_q;
    assign out_done    = done_q;
    assign out_table   = tbl_q;

endmodule

// File: tb/tb_f1_sweep_ctrl.sv
// tb_f1_sweep_ctrl: scoreboard bench for f1_sweep_ctrl with a
// behavioural f1 (optional y corruption) and an arithmetic reference.
module tb_f1_sweep_ctrl;

    typedef struct {
        logic        done;
        logic [15:0] tbl;
        logic [7:0]  mask;
        logic        pass;
        int          cycles;
    } exp_t;

`ifdef GOLDEN_CHECK_EN
    localparam bit GOLD = 1'b1;
`else
    localparam bit GOLD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, abort, x, y;
    logic        a, b, c, busy, done, pass;
    logic [2:0]  vidx;
    logic [15:0] tbl;
    logic [7:0]  emask;
    logic [7:0]  flip;

    logic        start0, abort0, x0, y0;
    logic        a0, b0, c0, busy0, done0, pass0;
    logic [2:0]  vidx0;
    logic [15:0] tbl0;
    logic [7:0]  emask0;

    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t q0[$];

    f1_sweep_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(start), .in_abort(abort),
        .in_x(x), .in_y(y), .out_a(a), .out_b(b), .out_c(c),
        .out_vec_idx(vidx), .out_busy(busy), .out_done(done),
        .out_table(tbl), .out_err_mask(emask), .out_pass(pass)
    );

    f1_sweep_ctrl #(.SETTLE_CYCLES(0), .CNT_W(4)) dut0 (
        .in_clk(clk), .in_rst_n(rst_n), .in_start(start0), .in_abort(abort0),
        .in_x(x0), .in_y(y0), .out_a(a0), .out_b(b0), .out_c(c0),
        .out_vec_idx(vidx0), .out_busy(busy0), .out_done(done0),
        .out_table(tbl0), .out_err_mask(emask0), .out_pass(pass0)
    );

    // f1 stand-ins; flip[] corrupts y for selected vectors
    always_comb begin
        x  = a ^ b;
        y  = ((x & c) | b) ^ flip[{a, b, c}];
        x0 = a0 ^ b0;
        y0 = (x0 & c0) | b0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_pair(input int i, input logic fl);
        int ra, rb, rc, rx, ry;
        ra = (i >> 2) & 1;
        rb = (i >> 1) & 1;
        rc = i & 1;
        rx = ra ^ rb;
        ry = ((rx & rc) | rb) ^ int'(fl);
        return 2'(rx * 2 + ry);
    endfunction

    // n = vectors captured; fin = sweep ran to completion
    function automatic exp_t model(input logic [7:0] fm, input int n,
                                   input bit fin, input int s);
        exp_t e;
        e.tbl  = '0;
        e.mask = '0;
        for (int i = 0; i < n; i++) begin
            e.tbl = e.tbl | (16'(ref_pair(i, fm[i])) << (2 * i));
            if (GOLD && fm[i]) e.mask = e.mask | 8'(1 << i);
        end
        e.done   = fin;
        e.pass   = GOLD && fin && (e.mask == 8'd0);
        e.cycles = fin ? 8 * (((s < 1) ? 1 : s) + 1) : -1;
        return e;
    endfunction

    task automatic end_check(input string tag, input exp_t e,
                             input logic d, input logic [15:0] t,
                             input logic [7:0] m, input logic p,
                             input logic [2:0] abc, input logic [2:0] vi,
                             input int cyc);
        chk({tag, "_done"}, d, e.done);
        chk({tag, "_table"}, t, e.tbl);
        chk({tag, "_err_mask"}, m, e.mask);
        chk({tag, "_pass"}, p, e.pass);
        chk({tag, "_abc_idle"}, abc, 3'd0);
        chk({tag, "_idx_idle"}, vi, 3'd0);
        if (e.cycles >= 0) chk({tag, "_busy_cycles"}, cyc, e.cycles);
    endtask

    // monitor for the SETTLE_CYCLES=2 instance
    initial begin
        int bc;
        logic bp;
        exp_t e;
        bc = 0;
        bp = 1'b0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) bc++;
            if (bp && busy === 1'b0) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m_unexpected_end: sweep ended with empty queue");
                end else begin
                    e = q.pop_front();
                    end_check("m", e, done, tbl, emask, pass,
                              {a, b, c}, vidx, bc);
                end
                bc = 0;
            end
            bp = (busy === 1'b1);
        end
    end

    // monitor for the SETTLE_CYCLES=0 instance
    initial begin
        int bc;
        logic bp;
        exp_t e;
        bc = 0;
        bp = 1'b0;
        forever begin
            @(negedge clk);
            if (busy0 === 1'b1) bc++;
            if (bp && busy0 === 1'b0) begin
                if (q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL m0_unexpected_end: sweep ended with empty queue");
                end else begin
                    e = q0.pop_front();
                    end_check("m0", e, done0, tbl0, emask0, pass0,
                              {a0, b0, c0}, vidx0, bc);
                end
                bc = 0;
            end
            bp = (busy0 === 1'b1);
        end
    end

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL timeout_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic wait_idx(input logic [2:0] want, input int lim);
        int n;
        n = 0;
        while (vidx !== want && n < lim) begin
            @(negedge clk);
            n++;
        end
        if (vidx !== want) begin
            checks++;
            errors++;
            $display("FAIL timeout_idx: idx=%0d expected %0d", vidx, want);
        end
    endtask

    task automatic sweep(input logic [7:0] fm, input int abort_at,
                         input bit pulses, input exp_t e);
        wait_idle(200);
        flip = fm;
        q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (abort_at >= 0) begin
            wait_idx(3'(abort_at), 200);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end else if (pulses) begin
            repeat (4) begin
                repeat ($urandom_range(1, 4)) @(negedge clk);
                if (busy && vidx < 3'd6) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
        end
        wait_idle(200);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        int dcnt;
        int ab;
        logic [7:0] fm;
        rst_n  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        start0 = 1'b0;
        abort0 = 1'b0;
        flip   = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_table", tbl, 16'd0);
        chk("rst_err_mask", emask, 8'd0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_idx", vidx, 3'd0);
        chk("rst_abc", {a, b, c}, 3'd0);
        chk("rst_busy0", busy0, 1'b0);

        // clean sweep
        e = '{done: 1'b1, tbl: 16'h5EF0, mask: 8'h00, pass: GOLD, cycles: 24};
        sweep(8'h00, -1, 1'b0, e);

        // y stuck at 0 on every vector that should yield y=1
        e = '{done: 1'b1, tbl: 16'h0AA0, mask: GOLD ? 8'hEC : 8'h00,
              pass: 1'b0, cycles: 24};
        sweep(8'hEC, -1, 1'b0, e);

        // abort in first settle cycle of vector 3
        e = '{done: 1'b0, tbl: 16'h0030, mask: 8'h00, pass: 1'b0, cycles: -1};
        sweep(8'h00, 3, 1'b0, e);

        // abort and start together while idle: nothing starts
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_start_busy", busy, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        // mid-sweep start pulses are ignored
        e = '{done: 1'b1, tbl: 16'h5EF0, mask: 8'h00, pass: GOLD, cycles: 24};
        sweep(8'h00, -1, 1'b1, e);

        // start held for 60 cycles: three accepted sweeps
        wait_idle(200);
        flip = 8'h00;
        e = '{done: 1'b1, tbl: 16'h5EF0, mask: 8'h00, pass: GOLD, cycles: 24};
        repeat (3) q.push_back(e);
        start = 1'b1;
        dcnt  = 0;
        repeat (60) begin
            @(negedge clk);
            if (done && !busy) dcnt++;
        end
        start = 1'b0;
        chk("b2b_done_pulses", dcnt, 2);
        wait_idle(200);
        @(negedge clk);

        // synchronous reset mid-sweep at vector 5
        e = '{done: 1'b0, tbl: 16'h0000, mask: 8'h00, pass: 1'b0, cycles: -1};
        q.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idx(3'd5, 200);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        e = '{done: 1'b1, tbl: 16'h5EF0, mask: 8'h00, pass: GOLD, cycles: 24};
        sweep(8'h00, -1, 1'b0, e);

        // randomized sweeps against the reference model
        for (int r = 0; r < 10; r++) begin
            fm = 8'($urandom);
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            sweep(fm, ab, 1'($urandom_range(0, 1)),
                  model(fm, (ab < 0) ? 8 : ab, ab < 0, 2));
        end

        // zero settle time instance
        q0.push_back('{done: 1'b1, tbl: 16'h5EF0, mask: 8'h00,
                       pass: GOLD, cycles: 16});
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (40) @(negedge clk);
        q0.push_back(model(8'h00, 4, 1'b0, 0));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int n = 0; n < 100 && vidx0 != 3'd4; n++) @(negedge clk);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        repeat (4) @(negedge clk);

        chk("queue_drained", q.size(), 0);
        chk("queue0_drained", q0.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
